// File: rtl/des_key_sched_pkg.sv
// Shared constants for the DES key schedule: default shift map, PC-2 table,
// FSM state type and the total-rotation helper.
package des_ks_pkg;

  localparam logic [15:0] DEF_SHIFT_MAP = 16'h8103;
  localparam int          PC2_W         = 48;

  // PC-2 selection, 1-based bit positions counted from the MSB of {C,D}.
  localparam int PC2_TAB [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [0:0] {
    KS_IDLE = 1'b0,
    KS_RUN  = 1'b1
  } ks_state_e;

  function automatic int total_shift(input logic [63:0] map, input int rounds);
    int t;
    t = 0;
    for (int i = 0; i < rounds; i++) begin
      if (map[i]) begin
        t = t + 1;
      end else begin
        t = t + 2;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/des_key_sched_if.sv
// Start/subkey handshake bundle of the key schedule.
// Subkey width follows KS_PC2_EN: 48 bits when defined, else 2*HALF_W.
interface des_key_sched_if #(
  parameter int HALF_W = 28,
  parameter int RW     = 4
);
`ifdef KS_PC2_EN
  localparam int SK_W = 48;
`else
  localparam int SK_W = 2 * HALF_W;
`endif

  logic                start;
  logic                mode;
  logic [2*HALF_W-1:0] key_in;
  logic                abort;
  logic                busy;
  logic                k_valid;
  logic                k_ready;
  logic [RW-1:0]       round;
  logic [SK_W-1:0]     subkey;
  logic                done;

  modport master (
    output start, mode, key_in, abort, k_ready,
    input  busy, k_valid, round, subkey, done
  );

  modport slave (
    input  start, mode, key_in, abort, k_ready,
    output busy, k_valid, round, subkey, done
  );

endinterface

// File: rtl/des_key_sched_rot.sv
// Combinational rotate of one key half by 1 or 2 places, left or right.
module ks_rot #(
  parameter int HALF_W = 28
) (
  input  logic [HALF_W-1:0] din,
  input  logic              shift_sel,
  input  logic              dir,
  output logic [HALF_W-1:0] dout
);

  // Pick one of the four rotations; dir = 1 rotates right, shift_sel = 1 moves one place.
  always_comb begin
    dout = din;
    case ({dir, shift_sel})
      2'b00:   dout = {din[HALF_W-3:0], din[HALF_W-1:HALF_W-2]};
      2'b01:   dout = {din[HALF_W-2:0], din[HALF_W-1]};
      2'b10:   dout = {din[1:0], din[HALF_W-1:2]};
      2'b11:   dout = {din[0], din[HALF_W-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key schedule: one round subkey per cycle over valid/ready.
// Define KS_PC2_EN to emit the 48-bit PC-2 selection instead of raw {C,D}.
module des_key_sched
  import des_ks_pkg::*;
#(
  parameter int                HALF_W    = 28,
  parameter int                ROUNDS    = 16,
  parameter logic [ROUNDS-1:0] SHIFT_MAP = ROUNDS'(DEF_SHIFT_MAP),
  parameter int                RW        = $clog2(ROUNDS)
) (
  input logic            clk,
  input logic            rst,
  des_key_sched_if.slave bus
);

  localparam int            DEC_ROT = total_shift(64'(SHIFT_MAP), ROUNDS) % HALF_W;
  localparam logic [RW-1:0] LAST    = RW'(ROUNDS - 1);

  ks_state_e         state_r, state_nxt_s;
  logic [HALF_W-1:0] c_r, d_r, c_nxt_s, d_nxt_s;
  logic [RW-1:0]     round_r, round_nxt_s;
  logic              kv_r, kv_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic              mode_r, mode_nxt_s;

  logic [HALF_W-1:0] key_c_s, key_d_s;
  logic [HALF_W-1:0] rot_c_in_s, rot_d_in_s, rot_c_out_s, rot_d_out_s;
  logic              rot_dir_s, rot_sel_s;
  logic [RW-1:0]     idx_s;

  function automatic logic [HALF_W-1:0] rotl_const(input logic [HALF_W-1:0] x, input int amt);
    logic [2*HALF_W-1:0] t;
    t = {x, x} << amt;
    return t[2*HALF_W-1:HALF_W];
  endfunction

  assign key_c_s = bus.key_in[2*HALF_W-1:HALF_W];
  assign key_d_s = bus.key_in[HALF_W-1:0];

  // Rotator inputs: the raw key for the encrypt load in IDLE, the live halves in RUN.
  always_comb begin
    idx_s      = '0;
    rot_c_in_s = c_r;
    rot_d_in_s = d_r;
    rot_dir_s  = 1'b0;
    rot_sel_s  = SHIFT_MAP[0];
    if (state_r == KS_IDLE) begin
      rot_c_in_s = key_c_s;
      rot_d_in_s = key_d_s;
      rot_dir_s  = 1'b0;
      rot_sel_s  = SHIFT_MAP[0];
    end else begin
      rot_dir_s = mode_r;
      if (mode_r) begin
        idx_s = LAST - round_r;
      end else if (round_r == LAST) begin
        idx_s = '0;
      end else begin
        idx_s = round_r + RW'(1);
      end
      rot_sel_s = SHIFT_MAP[idx_s];
    end
  end

  ks_rot #(.HALF_W(HALF_W)) u_rot_c (
    .din       (rot_c_in_s),
    .shift_sel (rot_sel_s),
    .dir       (rot_dir_s),
    .dout      (rot_c_out_s)
  );

  ks_rot #(.HALF_W(HALF_W)) u_rot_d (
    .din       (rot_d_in_s),
    .shift_sel (rot_sel_s),
    .dir       (rot_dir_s),
    .dout      (rot_d_out_s)
  );

  // Next-state logic; abort wins over a same-cycle handshake.
  always_comb begin
    state_nxt_s = state_r;
    c_nxt_s     = c_r;
    d_nxt_s     = d_r;
    round_nxt_s = round_r;
    kv_nxt_s    = kv_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    mode_nxt_s  = mode_r;
    case (state_r)
      KS_IDLE: begin
        if (bus.start) begin
          state_nxt_s = KS_RUN;
          mode_nxt_s  = bus.mode;
          round_nxt_s = '0;
          kv_nxt_s    = 1'b1;
          busy_nxt_s  = 1'b1;
          if (bus.mode) begin
            // Decrypt starts from the key rotated by the whole schedule's total.
            c_nxt_s = rotl_const(key_c_s, DEC_ROT);
            d_nxt_s = rotl_const(key_d_s, DEC_ROT);
          end else begin
            c_nxt_s = rot_c_out_s;
            d_nxt_s = rot_d_out_s;
          end
        end else begin
          state_nxt_s = KS_IDLE;
        end
      end
      KS_RUN: begin
        if (bus.abort) begin
          state_nxt_s = KS_IDLE;
          kv_nxt_s    = 1'b0;
          busy_nxt_s  = 1'b0;
        end else if (kv_r && bus.k_ready) begin
          if (round_r == LAST) begin
            state_nxt_s = KS_IDLE;
            kv_nxt_s    = 1'b0;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            round_nxt_s = round_r + RW'(1);
            c_nxt_s     = rot_c_out_s;
            d_nxt_s     = rot_d_out_s;
          end
        end else begin
          state_nxt_s = KS_RUN;
        end
      end
      default: begin
        state_nxt_s = KS_IDLE;
        kv_nxt_s    = 1'b0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= KS_IDLE;
      c_r     <= '0;
      d_r     <= '0;
      round_r <= '0;
      kv_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      c_r     <= c_nxt_s;
      d_r     <= d_nxt_s;
      round_r <= round_nxt_s;
      kv_r    <= kv_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      mode_r  <= mode_nxt_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.k_valid = kv_r;
  assign bus.round   = round_r;
  assign bus.done    = done_r;

`ifdef KS_PC2_EN
  if (HALF_W != 28) begin : g_pc2_width_chk
    $error("KS_PC2_EN requires HALF_W = 28");
  end

  logic [PC2_W-1:0] sk_r;

  function automatic logic [PC2_W-1:0] pc2_sel(input logic [55:0] cd);
    logic [PC2_W-1:0] r;
    r = '0;
    for (int i = 0; i < PC2_W; i++) begin
      r[PC2_W-1-i] = cd[56-PC2_TAB[i]];
    end
    return r;
  endfunction

  // PC-2 output register, loaded from the next halves so it lines up with round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk_r <= 48'h0;
    end else begin
      sk_r <= pc2_sel({c_nxt_s, d_nxt_s});
    end
  end

  assign bus.subkey = sk_r;
`else
  assign bus.subkey = {c_r, d_r};
`endif

endmodule

// File: doc/des_key_sched.md
Name: des_key_sched

Overview:
- Sequential DES-style key schedule generator that emits one round subkey per cycle over a valid/ready handshake.
- Holds the C/D halves (key already after PC-1) in registers.
- Per round, rotates each half by 1 or 2 positions from a parametrised shift map: left for encryption, right for decryption.
- Sits between the key loader and the Feistel round datapath; generalises the fixed 28-bit left-rotate stage to any half width, round count and direction.

Parameters:
- HALF_W, 28, width of each of the C and D halves.
- ROUNDS, 16, number of subkeys emitted per start.
- SHIFT_MAP, 16'h8103, bit i = 1: round i rotates by 1; bit i = 0: rotates by 2. Width ROUNDS.
- RW, $clog2(ROUNDS), width of the round index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a schedule run; accepted only in IDLE.
- mode  in  1  0 = encrypt (rotate left), 1 = decrypt (rotate right, reverse subkey order); sampled with start.
- key_in  in  2*HALF_W  {C,D} after PC-1; sampled with start.
- abort  in  1  terminate the current run.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- k_valid  out  1  subkey and round are valid.
- k_ready  in  1  consumer accepts the subkey.
- round  out  RW  index of the presented subkey, 0..ROUNDS-1.
- subkey  out  SK_W  round subkey; SK_W = 48 with KS_PC2_EN, else 2*HALF_W.
- done  out  1  one-cycle pulse after the last subkey handshake.

Behaviour:
- Reset (asynchronous, any time, including mid-run):
  - C, D, round, busy, k_valid and done clear to 0; the FSM goes to IDLE.
  - Outputs are valid immediately on reset assertion.
- FSM states are IDLE and RUN.
- IDLE -> RUN when start = 1:
  - Encrypt: the next edge loads C,D = rotl(key halves, s(0)).
  - Decrypt: the next edge loads C,D = rotl(key halves, TOTAL mod HALF_W). TOTAL = sum of the shift amounts; it is 28 for the defaults, so the halves load unrotated.
  - round <= 0, k_valid <= 1, busy <= 1. Latency from start to first valid subkey is 1 cycle.
- RUN, k_valid & !k_ready: all registers hold; subkey and round are stable.
- RUN, handshake (k_valid & k_ready) with round < ROUNDS-1:
  - round increments.
  - Encrypt: each half <= rotl(half, s(round+1)).
  - Decrypt: each half <= rotr(half, s(ROUNDS-1-round)).
  - k_valid stays 1, giving one subkey per cycle under continuous ready.
- RUN, handshake with round = ROUNDS-1: go to IDLE; k_valid <= 0, busy <= 0, done <= 1 for one cycle. round and C/D hold their last values.
- Shift amount s(i) = 1 if SHIFT_MAP[i] else 2. Rotation is modulo HALF_W; C and D rotate independently with no carry between halves.
- abort in RUN: next cycle goes to IDLE with k_valid = 0, busy = 0 and no done pulse. abort takes priority over a same-cycle handshake. abort in IDLE is ignored.
- start is ignored while busy, including in the done cycle's preceding handshake cycle. Back-to-back runs: start may be asserted in the cycle done is high.
- In decrypt mode, subkey j equals encrypt subkey ROUNDS-1-j for the same key.

Optional Feature:
- KS_PC2_EN defined: subkey = 48-bit PC-2 selection of {C,D}, registered alongside round, same latency. Legal only with HALF_W = 28; otherwise an elaboration error.
- Not defined: subkey = raw {C,D}, 2*HALF_W bits, and PC-2 is left to the round datapath.

Decomposition:
- Package des_ks_pkg holds:
  - the default SHIFT_MAP constant;
  - the PC-2 index table as a constant array;
  - a function returning TOTAL for a given map.
- Sub-module ks_rot: combinational rotate of one HALF_W half by 1 or 2, left or right, inputs shift_sel and dir. Instantiated twice, for C and D.

Test Plan:
- Encrypt, raw output, key_in = {28'h0, 28'h0000001}, k_ready = 1: D sequence over rounds 0..15 is 0000002, 0000004, 0000010, 0000040, 0000100, 0000400, 0001000, 0004000, 0008000, 0020000, 0080000, 0200000, 0800000, 2000000, 8000000, 0000001. done pulses one cycle after round 15.
- Decrypt, same key: round 0 D = 0000001, round 1 = 8000000, round 2 = 2000000, through round 15 = 0000002. This is the exact reverse of the encrypt sequence.
- Backpressure: k_ready low in rounds 3..5 for 4 cycles each. subkey and round hold, no round is skipped or duplicated, and a 16-handshake count precedes done.
- abort asserted at round 7 with a concurrent handshake: next cycle k_valid = 0, busy = 0, done = 0. A new start then begins at round 0.
- rst pulsed asynchronously at round 10 (between edges): all outputs are 0 immediately. start during busy is ignored, verified with round continuity.
- With KS_PC2_EN, standard DES key 133457799BBCDFF1 (after PC-1): round 0 subkey = 48'h1B02EFFC7072, round 15 = 48'hCB3D8B0E17F5.
